rr_grant_index_gen: RTL and testbench

- Round-robin arbiter that sits directly upstream of the 3-to-8 one-hot decoder stage.
- Takes 8 level-sensitive request lines and selects one fairly.
- Presents the winner as a registered 3-bit index with a valid/ready handshake; the index feeds the decoder's 3 select inputs.
- Guarantees the index is stable for as long as it is offered, so the decoder output never glitches between grants.

---
 rtl/rr_grant_pkg.sv | 17 +
 rtl/rr_pick.sv | 38 +++
 rtl/rr_grant_index_gen.sv | 98 +++++++++
 tb/tb_rr_grant_index_gen.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/rr_grant_pkg.sv
// rr_grant_pkg: shared constants and FSM state type for the round-robin grant index generator.
// Revision: 1.0
`default_nettype none

package rr_grant_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = $clog2(N_REQ);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_e;

endpackage : rr_grant_pkg

`default_nettype wire

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin search; first set request at or after start, wrapping.
// Revision: 1.0
`default_nettype none

module rr_pick
  import rr_grant_pkg::*;
(
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] start_i,
  output logic             found_o,
  output logic [IDX_W-1:0] idx_o
);

  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic [IDX_W-1:0]   off;

  // Doubling the vector turns the rotate into a plain shift; bit 0 of rot is channel start_i.
  assign dbl = {req_i, req_i} >> start_i;
  assign rot = dbl[N_REQ-1:0];

  always_comb begin
    off     = '0;
    found_o = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        off     = IDX_W'(i);
        found_o = 1'b1;
      end
    end
  end

  // IDX_W-bit addition wraps modulo N_REQ because N_REQ is a power of two.
  assign idx_o = start_i + off;

endmodule : rr_pick

`default_nettype wire

// File: rtl/rr_grant_index_gen.sv
// rr_grant_index_gen: round-robin arbiter presenting a stable registered 3-bit grant index with valid/ready.
// Revision: 1.0
`default_nettype none

module rr_grant_index_gen
  import rr_grant_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [N_REQ-1:0] req,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_vld,
  input  logic             grant_rdy,
  output logic [CNT_W-1:0] grant_cnt,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [IDX_W-1:0] pick_start;
  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;

  // While offering, the only search that matters is the handshake re-arbitration,
  // which starts just past the current winner (the value ptr is about to take).
  assign pick_start = (state_q == OFFER) ? (idx_q + IDX_W'(1)) : ptr_q;

  rr_pick u_pick (
    .req_i   (req),
    .start_i (pick_start),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;

    if (clr) begin
      state_d = IDLE;
      ptr_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_found) begin
            idx_d   = pick_idx;
            state_d = OFFER;
          end
        end
        OFFER: begin
          if (grant_rdy) begin
            ptr_d = idx_q + IDX_W'(1);
            if (!(&cnt_q)) begin
              cnt_d = cnt_q + CNT_W'(1);
            end
            if (pick_found) begin
              idx_d = pick_idx;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  // Valid is the state bit itself, so busy and grant_vld can never disagree.
  assign grant_vld = (state_q == OFFER);
  assign busy      = (state_q == OFFER);
  assign grant_idx = idx_q;
  assign grant_cnt = cnt_q;

endmodule : rr_grant_index_gen

`default_nettype wire

// File: tb/tb_rr_grant_index_gen.sv
// tb_rr_grant_index_gen: vector table, directed reset sequence and randomized run against a reference model.
// Revision: 1.0
`default_nettype none

module tb_rr_grant_index_gen;

  localparam int TB_CNT_W = 4;
  localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                clr;
  logic [7:0]          req;
  logic [2:0]          grant_idx;
  logic                grant_vld;
  logic                grant_rdy;
  logic [TB_CNT_W-1:0] grant_cnt;
  logic                busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rr_grant_index_gen #(.CNT_W(TB_CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .req       (req),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld),
    .grant_rdy (grant_rdy),
    .grant_cnt (grant_cnt),
    .busy      (busy)
  );

  typedef struct {
    logic [7:0] req;
    logic       rdy;
    logic       clr;
    logic       vld;
    int         idx;
    int         cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic vld, input int idx, input int cnt);
    check({tag, " vld"}, int'(grant_vld), int'(vld));
    check({tag, " busy"}, int'(busy), int'(vld));
    check({tag, " cnt"}, int'(grant_cnt), cnt);
    if (vld) check({tag, " idx"}, int'(grant_idx), idx);
  endtask

  // Inputs change 1 ns after a rising edge; outputs are checked at that same point.
  task automatic apply(input logic [7:0] r, input logic rdy, input logic c);
    req       = r;
    grant_rdy = rdy;
    clr       = c;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req = '0; grant_rdy = 1'b0; clr = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Reference: walk the channels from start in order, first requester wins.
  function automatic int find_winner(input logic [7:0] r, input int start);
    for (int k = 0; k < 8; k++) begin
      if (r[(start + k) % 8]) return (start + k) % 8;
    end
    return -1;
  endfunction

  int m_vld, m_idx, m_ptr, m_cnt;

  task automatic model_step(input logic [7:0] r, input logic rdy, input logic c);
    int w;
    if (c) begin
      m_vld = 0;
      m_ptr = 0;
    end else if (m_vld == 0) begin
      w = find_winner(r, m_ptr);
      if (w >= 0) begin
        m_idx = w;
        m_vld = 1;
      end
    end else if (rdy) begin
      m_ptr = (m_idx + 1) % 8;
      if (m_cnt < CNT_MAX) m_cnt++;
      w = find_winner(r, m_ptr);
      if (w >= 0) m_idx = w;
      else m_vld = 0;
    end
  endtask

  initial begin
    rst_n = 1'b0; req = '0; grant_rdy = 1'b0; clr = 1'b0;

    //               req    rdy   clr   vld   idx cnt
    vecs.push_back('{8'h04, 1'b0, 1'b0, 1'b1, 2, 0});
    vecs.push_back('{8'h04, 1'b1, 1'b0, 1'b1, 2, 1});
    vecs.push_back('{8'h00, 1'b1, 1'b0, 1'b0, 0, 2});
    vecs.push_back('{8'h00, 1'b0, 1'b1, 1'b0, 0, 2});
    for (int i = 0; i < 9; i++)
      vecs.push_back('{8'hFF, 1'b1, 1'b0, 1'b1, i % 8, 2 + i});
    vecs.push_back('{8'h00, 1'b1, 1'b0, 1'b0, 0, 11});
    vecs.push_back('{8'h88, 1'b0, 1'b0, 1'b1, 3, 11});
    vecs.push_back('{8'h88, 1'b0, 1'b0, 1'b1, 3, 11});
    vecs.push_back('{8'h00, 1'b0, 1'b0, 1'b1, 3, 11});
    vecs.push_back('{8'h00, 1'b0, 1'b0, 1'b1, 3, 11});
    vecs.push_back('{8'h00, 1'b0, 1'b0, 1'b1, 3, 11});
    vecs.push_back('{8'h00, 1'b1, 1'b0, 1'b0, 0, 12});
    vecs.push_back('{8'h80, 1'b0, 1'b0, 1'b1, 7, 12});
    vecs.push_back('{8'h81, 1'b1, 1'b0, 1'b1, 0, 13});
    vecs.push_back('{8'h81, 1'b1, 1'b0, 1'b1, 7, 14});
    vecs.push_back('{8'h81, 1'b1, 1'b0, 1'b1, 0, 15});
    vecs.push_back('{8'h81, 1'b1, 1'b0, 1'b1, 7, 15});
    vecs.push_back('{8'h00, 1'b1, 1'b0, 1'b0, 0, 15});
    vecs.push_back('{8'h10, 1'b0, 1'b0, 1'b1, 4, 15});
    vecs.push_back('{8'h11, 1'b1, 1'b1, 1'b0, 0, 15});
    vecs.push_back('{8'h11, 1'b0, 1'b0, 1'b1, 0, 15});

    do_reset();
    #1;
    check_outs("reset", 1'b0, 0, 0);
    check("reset idx", int'(grant_idx), 0);

    foreach (vecs[i]) begin
      apply(vecs[i].req, vecs[i].rdy, vecs[i].clr);
      check_outs($sformatf("vec%0d", i), vecs[i].vld, vecs[i].idx, vecs[i].cnt);
    end

    // Asynchronous reset in the middle of an offer to channel 5.
    apply(8'h20, 1'b1, 1'b0);
    check_outs("pre-async", 1'b1, 5, 15);
    #2;
    rst_n = 1'b0;
    #1;
    check_outs("async", 1'b0, 0, 0);
    check("async idx", int'(grant_idx), 0);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    apply(8'h20, 1'b0, 1'b0);
    check_outs("post-async", 1'b1, 5, 0);

    // Randomized run against the reference model.
    do_reset();
    m_vld = 0; m_idx = 0; m_ptr = 0; m_cnt = 0;
    for (int n = 0; n < 3000; n++) begin
      logic [7:0] r;
      logic       rdy, c;
      r   = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      rdy = ($urandom_range(0, 2) != 0);
      c   = ($urandom_range(0, 40) == 0);
      model_step(r, rdy, c);
      apply(r, rdy, c);
      check_outs($sformatf("rand%0d", n), m_vld[0], m_idx, m_cnt);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_rr_grant_index_gen

`default_nettype wire
